// File: rtl/ahb_man_ctrl_pkg.sv
// ahb_man_ctrl_pkg: AHB-Lite encodings and manager FSM states shared by the manager engine
package ahb_man_ctrl_pkg;
  typedef enum logic [1:0] {TR_IDLE = 2'd0, TR_BUSY = 2'd1, TR_NONSEQ = 2'd2, TR_SEQ = 2'd3} trans_t;
  typedef enum logic [2:0] {BU_SINGLE = 3'd0, BU_INCR = 3'd1} burst_t;
  typedef enum logic [1:0] {RE_OKAY = 2'd0, RE_ERROR = 2'd1} resp_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_DRAIN, S_ERR} state_t;
  function automatic logic [2:0] size_of(int dw);
    return 3'($clog2(dw / 8));
  endfunction
endpackage

// File: rtl/ahb_man_wbuf.sv
// ahb_man_wbuf: one-beat write holding register with valid/ready
module ahb_man_wbuf #(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_data,
  output logic                 out_valid,
  output logic [DataWidth-1:0] out_data,
  input  logic                 out_pop
);
  logic full;
  logic [DataWidth-1:0] data;
  assign in_ready = !full || out_pop;
  assign out_valid = full;
  assign out_data = data;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      full <= 1'b0;
      data <= '0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end else if (out_pop) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/ahb_man_ctrl.sv
// ahb_man_ctrl: AHB-Lite manager engine turning local burst commands into pipelined AHB transfers
module ahb_man_ctrl
  import ahb_man_ctrl_pkg::*;
#(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int MaxBeats = 16,
  localparam int LenWidth = $clog2(MaxBeats)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [AddrWidth-1:0] cmd_addr,
  input  logic [LenWidth-1:0]  cmd_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DataWidth-1:0] wr_data,
  output logic                 rd_valid,
  output logic [DataWidth-1:0] rd_data,
  output logic                 done,
  output logic                 done_err,
  output logic [AddrWidth-1:0] addr,
  output logic [1:0]           trans,
  output logic [2:0]           burst,
  output logic [2:0]           size,
  output logic                 write,
  output logic [DataWidth-1:0] wData,
  input  logic                 readyIn,
  input  logic [DataWidth-1:0] rData,
  input  logic [1:0]           resp
);
  localparam int Step = DataWidth / 8;
  localparam int CntWidth = LenWidth + 1;
  state_t st, st_n;
  trans_t trans_r, trans_n;
  burst_t burst_r, burst_n;
  logic [AddrWidth-1:0] addr_r, addr_n, addr_step;
  logic write_r, write_n, dp, dp_n, dp_last, dp_last_n;
  logic [LenWidth-1:0] len_r, len_n;
  logic [CntWidth-1:0] a_cnt, a_cnt_n, wr_cnt, wr_cnt_n, beats_n, len_ext;
  logic [DataWidth-1:0] wdata_r, wdata_n, buf_data;
  logic resp_err, is_addr, accept, hold, fin, active, flush_w, cmd_hs, wr_hs, push, pop;
  logic buf_valid, buf_in_ready, buf_flush, avail, more, first, seq_ok;

  ahb_man_wbuf #(.DataWidth(DataWidth)) u_wbuf (
    .clk(clk), .reset(reset), .flush(buf_flush), .in_valid(push), .in_ready(buf_in_ready),
    .in_data(wr_data), .out_valid(buf_valid), .out_data(buf_data), .out_pop(pop)
  );

  assign len_ext = {1'b0, len_r};
  assign resp_err = resp == RE_ERROR;
  assign is_addr = trans_r == TR_NONSEQ || trans_r == TR_SEQ;
  assign accept = readyIn && is_addr;
  assign hold = is_addr && !readyIn;
  assign fin = dp && readyIn && (resp_err || dp_last);
  assign active = st == S_ADDR || st == S_BURST;
  // after an error, leftover write beats of the command are swallowed before a new command
  assign flush_w = write_r && wr_cnt <= len_ext && (st == S_ERR || st == S_IDLE);
  assign cmd_ready = !reset && st == S_IDLE && !flush_w;
  assign cmd_hs = cmd_valid && cmd_ready;
  assign wr_ready = !reset && (flush_w || (buf_in_ready &&
                    (active ? write_r && wr_cnt <= len_ext : cmd_hs && cmd_write)));
  assign wr_hs = wr_valid && wr_ready;
  assign push = wr_hs && !flush_w;
  assign pop = accept && write_r;
  assign avail = !write_r || push || (buf_valid && !pop);
  assign beats_n = a_cnt + CntWidth'(accept);
  assign addr_step = accept ? addr_r + AddrWidth'(Step) : addr_r;
  assign more = beats_n <= len_ext;
  assign first = beats_n == '0;
  assign seq_ok = !first && addr_step[9:0] != '0;
  assign done = !reset && fin;
  assign done_err = done && resp_err;
  assign rd_valid = !reset && dp && readyIn && !resp_err && !write_r;
  assign rd_data = rData;
  assign addr = addr_r;
  assign trans = trans_r;
  assign burst = burst_r;
  assign size = size_of(DataWidth);
  assign write = write_r;
  assign wData = wdata_r;

  always_comb begin
    st_n = st;
    trans_n = trans_r;
    addr_n = addr_step;
    burst_n = burst_r;
    write_n = write_r;
    len_n = len_r;
    a_cnt_n = beats_n;
    wr_cnt_n = wr_cnt + CntWidth'(wr_hs);
    dp_n = readyIn ? accept : dp;
    dp_last_n = readyIn ? accept && a_cnt == len_ext : dp_last;
    wdata_n = pop ? buf_data : wdata_r;
    buf_flush = 1'b0;
    case (st)
      S_IDLE: if (cmd_hs) begin
        st_n = S_ADDR;
        trans_n = (!cmd_write || wr_hs) ? TR_NONSEQ : TR_IDLE;
        addr_n = cmd_addr;
        burst_n = cmd_len == '0 ? BU_SINGLE : BU_INCR;
        write_n = cmd_write;
        len_n = cmd_len;
        a_cnt_n = '0;
        wr_cnt_n = CntWidth'(wr_hs);
      end
      S_ADDR, S_BURST: begin
        st_n = !more ? S_DRAIN : first ? S_ADDR : S_BURST;
        if (!hold)
          trans_n = !more ? TR_IDLE : avail ? (seq_ok ? TR_SEQ : TR_NONSEQ) : first ? TR_IDLE : TR_BUSY;
      end
      default: ;
    endcase
    if (dp && !readyIn && resp_err && st != S_ERR) begin
      st_n = S_ERR;
      trans_n = TR_IDLE;
      buf_flush = 1'b1;
    end
    if (fin) begin
      st_n = S_IDLE;
      trans_n = TR_IDLE;
      dp_n = 1'b0;
      buf_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st <= S_IDLE;
      trans_r <= TR_IDLE;
      burst_r <= BU_SINGLE;
      addr_r <= '0;
      write_r <= 1'b0;
      len_r <= '0;
      a_cnt <= '0;
      wr_cnt <= '0;
      dp <= 1'b0;
      dp_last <= 1'b0;
      wdata_r <= '0;
    end else begin
      st <= st_n;
      trans_r <= trans_n;
      burst_r <= burst_n;
      addr_r <= addr_n;
      write_r <= write_n;
      len_r <= len_n;
      a_cnt <= a_cnt_n;
      wr_cnt <= wr_cnt_n;
      dp <= dp_n;
      dp_last <= dp_last_n;
      wdata_r <= wdata_n;
    end
  end
endmodule

// File: tb/tb_ahb_man_ctrl.sv
// tb_ahb_man_ctrl: directed and randomized bursts against a beat-level model of the AHB manager
module tb_ahb_man_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = '0;
  logic rd_valid, done, done_err, write;
  logic [31:0] rd_data, addr, wData;
  logic [1:0] trans;
  logic [2:0] burst, size;
  logic readyIn = 1'b1;
  logic [31:0] rData = '0;
  logic [1:0] resp = '0;
  int checks = 0, failures = 0;

  ahb_man_ctrl dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .done_err(done_err), .addr(addr), .trans(trans),
    .burst(burst), .size(size), .write(write), .wData(wData), .readyIn(readyIn), .rData(rData), .resp(resp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command seen from both the requester and the subordinate side; the model is the beat list.
  task automatic run_cmd(input bit w, input logic [31:0] a0, input int len, input int err_beat,
                         input int wait_pct, input int stall_pct);
    logic [31:0] wq[$];
    logic [31:0] ea;
    int na, dph, nw, nrd, cyc, done_cyc, err_ph, k;
    bit fin, ap;
    for (int i = 0; i <= len; i++) wq.push_back($urandom);
    na = 0; dph = -1; nw = 0; nrd = 0; err_ph = 0; fin = 0; done_cyc = -1; cyc = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a0; cmd_len = 4'(len);
    wr_valid = w && ($urandom_range(99) >= stall_pct); wr_data = wq[0];
    readyIn = 1'b1; resp = 2'd0; rData = $urandom;
    @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    chk("wr_ready_cmd", wr_ready, w);
    chk("done_idle", done, 0);
    if (wr_valid && wr_ready) nw++;
    while (!fin && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      cmd_valid = 1'b0;
      wr_valid = w && nw <= len && ($urandom_range(99) >= stall_pct);
      wr_data = nw <= len ? wq[nw] : 32'h0;
      rData = $urandom;
      resp = 2'd0;
      if (dph >= 0 && dph == err_beat) begin
        err_ph++;
        readyIn = err_ph == 2;
        resp = 2'd1;
      end else readyIn = $urandom_range(99) >= wait_pct;
      @(negedge clk);
      ap = trans == 2'd2 || trans == 2'd3;
      if (ap) begin
        ea = a0 + 32'(4 * na);
        chk("addr", addr, ea);
        chk("trans", trans, (na == 0 || ea[9:0] == 10'd0) ? 2 : 3);
        chk("write", write, w);
        chk("burst", burst, len == 0 ? 0 : 1);
        chk("size", size, 2);
        chk("beat_range", na <= len, 1);
        if (w) chk("wdata_held", nw > na, 1);
      end else if (trans == 2'd1) begin
        chk("busy_beat", na > 0 && na <= len, 1);
        chk("busy_addr", addr, a0 + 32'(4 * na));
      end
      if (err_ph == 2) chk("err_trans_idle", trans, 0);
      chk("cmd_ready_busy", cmd_ready, 0);
      if (w && nw > len) chk("wr_ready_over", wr_ready, 0);
      if (wr_valid && wr_ready) nw++;
      if (dph >= 0 && readyIn) begin
        if (resp == 2'd1) begin
          chk("done_on_err", done, 1);
          chk("done_err", done_err, 1);
          chk("rd_valid_err", rd_valid, 0);
          fin = 1;
        end else begin
          chk("done", done, dph == len);
          chk("done_err_ok", done_err, 0);
          chk("rd_valid", rd_valid, !w);
          if (!w) begin
            chk("rd_data", rd_data, rData);
            nrd++;
          end else chk("wData", wData, wq[dph]);
          fin = dph == len;
        end
        if (fin) done_cyc = cyc;
      end else begin
        chk("done_quiet", done, 0);
        chk("rd_quiet", rd_valid, 0);
      end
      if (readyIn) begin
        dph = ap ? na : -1;
        if (ap) na++;
      end
    end
    chk("cmd_finished", fin, 1);
    if (err_beat < 0) begin
      chk("beats_issued", na, len + 1);
      if (!w) chk("rd_count", nrd, len + 1);
      if (wait_pct == 0 && stall_pct == 0) chk("latency", done_cyc, len + 2);
    end
    k = 0;
    while (w && nw <= len && k < 100) begin
      @(posedge clk); #1;
      k++;
      wr_valid = 1'b1; wr_data = wq[nw]; readyIn = 1'b1; resp = 2'd0;
      @(negedge clk);
      chk("drain_wr_ready", wr_ready, 1);
      chk("drain_cmd_ready", cmd_ready, 0);
      chk("drain_trans", trans, 0);
      if (wr_valid && wr_ready) nw++;
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; readyIn = 1'b1; resp = 2'd0;
  endtask

  initial begin
    int len;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    @(negedge clk);
    chk("rst_trans", trans, 0);
    chk("rst_addr", addr, 0);
    chk("rst_burst", burst, 0);
    chk("rst_write", write, 0);
    chk("rst_wData", wData, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    run_cmd(0, 32'h100, 0, -1, 0, 0);
    run_cmd(1, 32'h200, 3, -1, 0, 40);
    run_cmd(0, 32'h100, 3, -1, 50, 0);
    run_cmd(0, 32'h3F8, 3, -1, 0, 0);
    run_cmd(1, 32'h3F0, 7, -1, 30, 30);
    run_cmd(1, 32'h1000, 7, 3, 0, 30);
    run_cmd(0, 32'h2000, 5, 2, 20, 0);
    run_cmd(1, 32'h0, 0, 0, 0, 0);
    run_cmd(1, 32'h40, 15, -1, 0, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_len = 4'd7; readyIn = 1'b1;
    @(negedge clk);
    chk("mid_cmd_ready", cmd_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_trans", trans, 0);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_done2", done, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    run_cmd(0, 32'h80, 3, -1, 0, 0);
    for (int i = 0; i < 25; i++) begin
      len = $urandom_range(15);
      run_cmd(1'($urandom_range(1)), $urandom & 32'h0000_0FFC, len,
              $urandom_range(3) == 0 ? int'($urandom_range(len)) : -1,
              $urandom_range(60), $urandom_range(60));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
